// File: rtl/gci_irq_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gci_irq_arbiter: GCI node IRQ arbiter (priority + round-robin) feeding a CPU IRQ FIFO.
// Optional GCI_IRQ_ARB_COALESCE_EN: suppress duplicate queue entries per node.
// Revision: 1.0
// ---------------------------------------------------------------------------
module gci_irq_arbiter #(
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
) (
  input  logic                 iCLOCK,
  input  logic                 iRESET_SYNC,
  input  logic                 iIRQ_CTRL_REQ,
  input  logic [1:0]           iIRQ_CTRL_ENTRY,
  input  logic                 iIRQ_CTRL_INFO_MASK,
  input  logic                 iIRQ_CTRL_INFO_VALID,
  input  logic                 iNODEINF_VALID,
  input  logic [31:0]          iNODE_PRIORITY,
  input  logic [3:0]           iNODE_IRQ,
  output logic [3:0]           oNODE_ACK,
  output logic                 oIRQ_BUSY,
  output logic                 oIRQ_VALID,
  output logic [5:0]           oIRQ_NUM,
  input  logic                 iIRQ_ACK,
  output logic [P_DEPTH_N:0]   oIRQ_COUNT
);

  localparam logic [P_DEPTH_N:0] C_FULL = (P_DEPTH_N+1)'(P_DEPTH);

  logic [3:0]           mask_q;
  logic [3:0]           valid_q;
  logic [3:0]           holdoff_q;
  logic [1:0]           rr_ptr_q;
  logic [5:0]           fifo_q [P_DEPTH];
  logic [P_DEPTH_N-1:0] wr_ptr_q;
  logic [P_DEPTH_N-1:0] rd_ptr_q;
  logic [P_DEPTH_N:0]   count_q;
  logic [P_DEPTH_N:0]   count_d;

  logic [3:0] w_elig;
  logic [1:0] w_idx;
  logic [1:0] w_winner;
  logic [7:0] w_best;
  logic [7:0] w_prio;
  logic       w_found;
  logic       w_full;
  logic       w_pop;
  logic       w_grant;
  logic       w_push;
  logic [5:0] w_num;

  assign w_elig = iNODE_IRQ & (~valid_q | mask_q) & ~holdoff_q;
  assign w_full = (count_q == C_FULL);
  assign w_pop  = iIRQ_ACK && (count_q != '0);
  assign w_num  = 6'(w_winner) + 6'd1;

  // Scan starts at rr_ptr; only a strictly larger priority displaces the
  // current pick, so the first equal-maximum node in scan order wins.
  always_comb begin
    w_winner = rr_ptr_q;
    w_best   = 8'd0;
    w_found  = 1'b0;
    w_idx    = rr_ptr_q;
    w_prio   = 8'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx  = rr_ptr_q + 2'(k);
      w_prio = iNODE_PRIORITY[8*w_idx +: 8];
      if (w_elig[w_idx] && (!w_found || (w_prio > w_best))) begin
        w_found  = 1'b1;
        w_best   = w_prio;
        w_winner = w_idx;
      end
    end
  end

`ifdef GCI_IRQ_ARB_COALESCE_EN
  logic [3:0] inq_q;
  logic [3:0] inq_d;
  logic [3:0] w_pop_clr;
  logic [3:0] w_inq_eff;
  logic       w_coal;

  always_comb begin
    w_pop_clr = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      w_pop_clr[n] = w_pop && (oIRQ_NUM == 6'(n + 1));
    end
  end

  // A flag whose entry leaves the FIFO this cycle no longer blocks a push.
  assign w_inq_eff = inq_q & ~w_pop_clr;
  assign w_coal    = w_inq_eff[w_winner];
  assign w_grant   = !iRESET_SYNC && iNODEINF_VALID && w_found && (!w_full || w_coal);
  assign w_push    = w_grant && !w_coal;
  assign inq_d     = w_inq_eff | (w_push ? oNODE_ACK : 4'b0000);

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      inq_q <= 4'b0000;
    end else begin
      inq_q <= inq_d;
    end
  end
`else
  assign w_grant = !iRESET_SYNC && iNODEINF_VALID && w_found && !w_full;
  assign w_push  = w_grant;
`endif

  assign oNODE_ACK = w_grant ? (4'b0001 << w_winner) : 4'b0000;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (P_DEPTH_N+1)'(1);
      2'b01:   count_d = count_q - (P_DEPTH_N+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      mask_q    <= 4'b0000;
      valid_q   <= 4'b0000;
      holdoff_q <= 4'b0000;
      rr_ptr_q  <= 2'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < P_DEPTH; i++) begin
        fifo_q[i] <= 6'd0;
      end
    end else begin
      if (iIRQ_CTRL_REQ) begin
        mask_q[iIRQ_CTRL_ENTRY]  <= iIRQ_CTRL_INFO_MASK;
        valid_q[iIRQ_CTRL_ENTRY] <= iIRQ_CTRL_INFO_VALID;
      end
      // One-cycle holdoff gives the acked node time to drop its level.
      holdoff_q <= oNODE_ACK;
      if (w_grant) begin
        rr_ptr_q <= w_winner + 2'd1;
      end
      if (w_push) begin
        fifo_q[wr_ptr_q] <= w_num;
        wr_ptr_q         <= wr_ptr_q + P_DEPTH_N'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + P_DEPTH_N'(1);
      end
      count_q <= count_d;
    end
  end

  assign oIRQ_VALID = (count_q != '0);
  assign oIRQ_NUM   = fifo_q[rd_ptr_q];
  assign oIRQ_COUNT = count_q;
  assign oIRQ_BUSY  = !iNODEINF_VALID || w_full;

endmodule
`default_nettype wire

// File: tb/tb_gci_irq_arbiter.sv
`default_nettype none
// tb_gci_irq_arbiter: directed stimulus with expected acks and IRQ numbers queued
// for a separate negedge monitor; state checks are made inline.
module tb_gci_irq_arbiter;

  logic        clk;
  logic        rst;
  logic        ctrl_req;
  logic [1:0]  entry;
  logic        mmask;
  logic        mvalid;
  logic        nvalid;
  logic [31:0] prio;
  logic [3:0]  irq;
  logic [3:0]  ack_o;
  logic        busy;
  logic        irq_valid;
  logic [5:0]  num;
  logic        cpu_ack;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [3:0] qa [$];
  logic [5:0] qn [$];
  logic [3:0] ea;
  logic [5:0] en;

`ifdef GCI_IRQ_ARB_COALESCE_EN
  localparam int EXP_DUP = 1;
`else
  localparam int EXP_DUP = 2;
`endif

  gci_irq_arbiter #(.P_DEPTH(4), .P_DEPTH_N(2)) dut (
    .iCLOCK               (clk),
    .iRESET_SYNC          (rst),
    .iIRQ_CTRL_REQ        (ctrl_req),
    .iIRQ_CTRL_ENTRY      (entry),
    .iIRQ_CTRL_INFO_MASK  (mmask),
    .iIRQ_CTRL_INFO_VALID (mvalid),
    .iNODEINF_VALID       (nvalid),
    .iNODE_PRIORITY       (prio),
    .iNODE_IRQ            (irq),
    .oNODE_ACK            (ack_o),
    .oIRQ_BUSY            (busy),
    .oIRQ_VALID           (irq_valid),
    .oIRQ_NUM             (num),
    .iIRQ_ACK             (cpu_ack),
    .oIRQ_COUNT           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic expect_grant(input logic [3:0] a, input logic [5:0] n, input bit push);
    qa.push_back(a);
    if (push) qn.push_back(n);
  endtask

  // Monitor: every ack pulse and every CPU pop is matched against the queues.
  always @(negedge clk) begin
    if (ack_o != 4'b0000) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected got=%b want=none", ack_o);
      end else begin
        ea = qa.pop_front();
        if (ack_o !== ea) begin
          errors++;
          $display("FAIL ack_value got=%b want=%b", ack_o, ea);
        end
      end
    end
    if (irq_valid && cpu_ack) begin
      checks++;
      if (qn.size() == 0) begin
        errors++;
        $display("FAIL irq_num_unexpected got=%0d want=none", num);
      end else begin
        en = qn.pop_front();
        if (num !== en) begin
          errors++;
          $display("FAIL irq_num got=%0d want=%0d", num, en);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    rst = 1; ctrl_req = 0; entry = 0; mmask = 0; mvalid = 0;
    nvalid = 0; prio = 0; irq = 0; cpu_ack = 0;
    tick(); at_neg();
    chk("rst_count", count, 0);
    chk("rst_valid", irq_valid, 0);
    chk("rst_num", num, 0);
    chk("rst_busy_noinfo", busy, 1);

    // single request from node index 2
    tick(); rst = 0; nvalid = 1; prio = {8'd20, 8'd50, 8'd50, 8'd10};
    irq = 4'b0100; expect_grant(4'b0100, 6'd3, 1);
    at_neg(); chk("idle_busy", busy, 0); chk("pre_push_valid", irq_valid, 0);
    tick(); irq = 4'b0000;
    at_neg(); chk("t1_valid", irq_valid, 1); chk("t1_count", count, 1); chk("t1_num", num, 3);
    tick(); cpu_ack = 1;
    tick(); cpu_ack = 0; chk("t1_acks_done", qa.size(), 0);
    at_neg(); chk("t1_count_popped", count, 0); chk("t1_valid_popped", irq_valid, 0);

    // tie between indices 1 and 2 alternates; FIFO fills and stalls
    tick(); irq = 4'b1111; expect_grant(4'b0010, 6'd2, 1);
    tick(); expect_grant(4'b0100, 6'd3, 1);
    tick(); expect_grant(4'b0010, 6'd2, 1);
    tick(); expect_grant(4'b0100, 6'd3, 1);
    tick(); at_neg(); chk("full_count", count, 4); chk("full_busy", busy, 1);
    // full with a pop: no bypass, then grant next cycle
    tick(); cpu_ack = 1; at_neg(); chk("full_pop_count", count, 4);
    tick(); cpu_ack = 0; expect_grant(4'b0010, 6'd2, 1);
    at_neg(); chk("after_pop_count", count, 3);
    tick(); irq = 4'b0000; chk("t2_acks_done", qa.size(), 0);
    at_neg(); chk("refill_count", count, 4);
    repeat (4) begin tick(); cpu_ack = 1; end
    tick(); at_neg(); chk("drained_count", count, 0);
    tick(); cpu_ack = 0; at_neg(); chk("empty_ack_ignored", count, 0);
    chk("t2_nums_done", qn.size(), 0);

    // valid=1 mask=0 blocks index 1; setting mask=1 re-enables it
    tick(); ctrl_req = 1; entry = 2'd1; mmask = 0; mvalid = 1;
    tick(); ctrl_req = 0; irq = 4'b0010;
    tick(); at_neg(); chk("masked_valid", irq_valid, 0);
    tick(); ctrl_req = 1; entry = 2'd1; mmask = 1; mvalid = 1;
    tick(); ctrl_req = 0; expect_grant(4'b0010, 6'd2, 1);
    tick(); irq = 4'b0000; chk("t3_acks_done", qa.size(), 0);
    at_neg(); chk("t3_count", count, 1);
    tick(); cpu_ack = 1;
    tick(); cpu_ack = 0; at_neg(); chk("t3_count_popped", count, 0);

    // table write in the request cycle uses the old value
    tick(); ctrl_req = 1; entry = 2'd0; mmask = 0; mvalid = 1;
    irq = 4'b0001; expect_grant(4'b0001, 6'd1, 1);
    tick(); ctrl_req = 0;
    tick(); at_neg(); chk("blocked_count", count, 1);
    tick(); irq = 4'b0000; chk("t4_acks_done", qa.size(), 0); cpu_ack = 1;
    tick(); cpu_ack = 0; ctrl_req = 1; entry = 2'd0; mmask = 0; mvalid = 0;
    tick(); ctrl_req = 0; at_neg(); chk("t4_count_popped", count, 0);

    // node info not valid: busy, no grant
    tick(); nvalid = 0; irq = 4'b1000; at_neg(); chk("noinfo_busy", busy, 1);
    tick(); nvalid = 1; expect_grant(4'b1000, 6'd4, 1);
    at_neg(); chk("info_busy", busy, 0);
    tick(); irq = 4'b0000; chk("t5_acks_done", qa.size(), 0);

    // reset mid-operation flushes the queue, no ack in reset cycle
    tick(); rst = 1; irq = 4'b0100;
    tick(); rst = 0; irq = 4'b0000; qn.delete();
    at_neg(); chk("reset_flush_count", count, 0); chk("reset_flush_valid", irq_valid, 0);
    chk("reset_flush_num", num, 0);

    // repeated request from index 0 before the CPU pops
    tick(); irq = 4'b0001; expect_grant(4'b0001, 6'd1, 1);
    tick(); irq = 4'b0000;
    tick(); irq = 4'b0001; expect_grant(4'b0001, 6'd1, EXP_DUP == 2);
    tick(); irq = 4'b0000; chk("t6_acks_done", qa.size(), 0);
    at_neg(); chk("dup_count", count, EXP_DUP);
    repeat (EXP_DUP) begin tick(); cpu_ack = 1; end
    tick(); cpu_ack = 0; at_neg(); chk("t6_count_popped", count, 0);

    tick();
    chk("final_acks", qa.size(), 0);
    chk("final_nums", qn.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
